// File: rtl/ror_unit_pkg.sv
// Shared ALU definitions: operand/rotate-amount widths and the 64-bit Z result pair.
package ror_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_BITS = 5;

  typedef struct packed {
    logic [DATA_W-1:0] zhigh;
    logic [DATA_W-1:0] zlow;
  } z_t;

endpackage : ror_unit_pkg

// File: rtl/ror_barrel.sv
// Combinational logarithmic rotate-right network; stage s rotates by 2^s when shamt[s] is set.
module ror_barrel
  import ror_unit_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = SHAMT_BITS
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign stage[0] = din;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int AMT = 1 << s;
    assign stage[s+1] = shamt[s] ? {stage[s][AMT-1:0], stage[s][WIDTH-1:AMT]}
                                 : stage[s];
  end

  assign dout = stage[SHAMT_W];

endmodule : ror_barrel

// File: rtl/ror_unit.sv
// Registered 32-bit rotate-right unit: one-cycle latency, one operation per cycle, no backpressure.
module ror_unit
  import ror_unit_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = SHAMT_BITS
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] Zlow,
  output logic [WIDTH-1:0] Zhigh,
  output logic             out_valid
);

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] zlow_q;
  logic             valid_q;
  z_t               z;

  // Upper rotate-amount bits are architecturally ignored.
  logic unused_y_hi;
  assign unused_y_hi = ^y[WIDTH-1:SHAMT_W];

  ror_barrel #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_barrel (
    .din   (x),
    .shamt (y[SHAMT_W-1:0]),
    .dout  (rot)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      zlow_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Load only on a valid op, so idle-cycle X on x/y never reaches Zlow.
      if (in_valid) begin
        zlow_q <= rot;
      end
    end
  end

  assign z         = '{zhigh: '0, zlow: zlow_q};
  assign Zlow      = z.zlow;
  assign Zhigh     = z.zhigh;
  assign out_valid = valid_q;

endmodule : ror_unit

// File: tb/tb_ror_unit.sv
// Self-checking bench for ror_unit: directed vectors, back-to-back, random ops, async reset.
module tb_ror_unit;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] Zlow;
  logic [31:0] Zhigh;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_z;
  logic        exp_v;

  ror_unit dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .Zlow      (Zlow),
    .Zhigh     (Zhigh),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: result bit i comes from source bit (i + n) mod 32, n = y mod 32.
  function automatic logic [31:0] ror_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int n;
    n = int'(b % 32);
    for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
    check({tag, ".zlow"},  64'(Zlow),      64'(exp_z));
    check({tag, ".zhigh"}, 64'(Zhigh),     64'h0);
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clock);
    in_valid = v;
    x        = v ? xv : 'x;
    y        = v ? yv : 'x;
    @(posedge clock);
    #1;
    exp_v = v;
    if (v) exp_z = ror_model(xv, yv);
    check_outputs(tag);
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    exp_z    = '0;
    exp_v    = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check_outputs("rst_init");

    // Op presented while in reset is discarded.
    @(negedge clock);
    in_valid = 1'b1;
    x        = 32'hDEADBEEF;
    y        = 32'd3;
    @(posedge clock);
    #1;
    check_outputs("rst_discard");
    @(negedge clock);
    in_valid = 1'b0;
    #2 resetn = 1'b1;

    // Directed vectors.
    step("d_55_7",   1'b1, 32'h55555555, 32'd7);
    check("d_55_7.lit", 64'(Zlow), 64'hAAAAAAAA);
    step("d_3_7",    1'b1, 32'h00000003, 32'd7);
    check("d_3_7.lit", 64'(Zlow), 64'h06000000);
    step("d_1_7",    1'b1, 32'h00000001, 32'd7);
    check("d_1_7.lit", 64'(Zlow), 64'h02000000);
    step("d_aa_7",   1'b1, 32'hAAAAAAAA, 32'd7);
    check("d_aa_7.lit", 64'(Zlow), 64'h55555555);
    step("d_y0",     1'b1, 32'h12345678, 32'd0);
    check("d_y0.lit", 64'(Zlow), 64'h12345678);
    step("d_y32",    1'b1, 32'h12345678, 32'd32);
    check("d_y32.lit", 64'(Zlow), 64'h12345678);
    step("d_y39",    1'b1, 32'h000000F0, 32'd39);
    check("d_y39.lit", 64'(Zlow), 64'hE0000001);
    step("d_msb_1",  1'b1, 32'h80000001, 32'd1);
    check("d_msb_1.lit", 64'(Zlow), 64'hC0000000);
    step("d_msb_31", 1'b1, 32'h80000001, 32'd31);
    check("d_msb_31.lit", 64'(Zlow), 64'h00000003);

    // Back-to-back then idle: out_valid drops, Zlow holds.
    step("b2b_0", 1'b1, 32'h0000F00D, 32'd4);
    step("b2b_1", 1'b1, 32'hCAFEBABE, 32'd16);
    step("b2b_2", 1'b1, 32'h0F0F0F0F, 32'd9);
    step("idle_0", 1'b0, '0, '0);
    check("idle_0.hold", 64'(Zlow), 64'(ror_model(32'h0F0F0F0F, 32'd9)));
    step("idle_1", 1'b0, '0, '0);

    // Random stream with random valid and full-width y.
    for (int i = 0; i < 200; i++) begin
      logic        v;
      logic [31:0] xv;
      logic [31:0] yv;
      v  = ($urandom_range(0, 3) != 0);
      xv = $urandom;
      yv = $urandom;
      step($sformatf("rnd%0d", i), v, xv, yv);
      if (v) check($sformatf("rnd%0d.popcnt", i), 64'($countones(Zlow)), 64'($countones(xv)));
    end

    // Asynchronous reset mid-stream, between clock edges.
    step("pre_rst", 1'b1, 32'h13579BDF, 32'd5);
    @(negedge clock);
    in_valid = 1'b1;
    x        = 32'hFFFF0000;
    y        = 32'd8;
    #2 resetn = 1'b0;
    #1;
    exp_z = '0;
    exp_v = 1'b0;
    check_outputs("async_rst");
    @(posedge clock);
    #1;
    check_outputs("async_rst_edge");
    @(negedge clock);
    in_valid = 1'b0;
    #2 resetn = 1'b1;
    step("post_rst", 1'b1, 32'h0000ABCD, 32'd12);
    check("post_rst.lit", 64'(Zlow), 64'hBCD0000A);
    step("post_idle", 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ror_unit
